vc_arbiter: RTL and testbench

Two-virtual-channel arbiter and destination router for the transaction layer, sitting directly downstream of the VC0/VC1 transaction FIFOs and upstream of the D0/D1 destination FIFOs. Each cycle it pops at most one word from a source FIFO and pushes it one cycle later into the destination FIFO selected by a header bit. VC0 has priority, with a bounded burst so VC1 is never starved. Pushes are withheld whenever the target destination is almost full.

---
 rtl/vc_arbiter.sv | 112 +++++++++++
 tb/tb_vc_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// vc_arbiter: two-virtual-channel arbiter and destination router.
// Pops at most one word per cycle from the VC0/VC1 source FIFOs. One cycle later
// it pushes that word into the D0 or D1 destination FIFO, chosen by a header bit.
// VC0 has priority, but only for a bounded burst while VC1 is waiting.
// A source whose destination is almost full is skipped, so it never blocks the
// other channel.

module vc_arbiter #(
    parameter int LINE_SIZE = 12,
    parameter int DEST_BIT  = 11,
    parameter int BURST     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LINE_SIZE-1:0] vc0_data,
    input  logic                 vc0_empty,
    output logic                 vc0_pop,
    input  logic [LINE_SIZE-1:0] vc1_data,
    input  logic                 vc1_empty,
    output logic                 vc1_pop,
    input  logic                 d0_almost_full,
    input  logic                 d1_almost_full,
    output logic                 d0_push,
    output logic                 d1_push,
    output logic [LINE_SIZE-1:0] data_out,
    output logic                 idle
);

    localparam int             CNT_W     = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VC0,
        GNT_VC1
    } grant_e;

    grant_e               grant;
    logic [CNT_W-1:0]     burst_cnt;
    logic                 vc0_dest;
    logic                 vc1_dest;
    logic                 eligible_vc0;
    logic                 eligible_vc1;
    logic [LINE_SIZE-1:0] gnt_data;
    logic                 gnt_dest;

    // A channel is eligible when it has a head word and that word's destination can accept it.
    always_comb begin
        vc0_dest     = vc0_data[DEST_BIT];
        vc1_dest     = vc1_data[DEST_BIT];
        eligible_vc0 = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
        eligible_vc1 = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
    end

    // Grant selection: a full VC0 burst yields to a waiting VC1, otherwise VC0 first.
    always_comb begin
        // NOTE: default assignment first so every path drives grant; no latch is inferred.
        grant = GNT_NONE;
        if (burst_cnt == BURST_MAX && eligible_vc1) begin
            grant = GNT_VC1;
        end else if (eligible_vc0) begin
            grant = GNT_VC0;
        end else if (eligible_vc1) begin
            grant = GNT_VC1;
        end
    end

    // Word and destination of the granted channel, registered on the next edge.
    always_comb begin
        gnt_data = (grant == GNT_VC1) ? vc1_data : vc0_data;
        gnt_dest = (grant == GNT_VC1) ? vc1_dest : vc0_dest;
    end

    // Pops are combinational from the grant and are held low while reset is asserted.
    assign vc0_pop = reset && (grant == GNT_VC0);
    assign vc1_pop = reset && (grant == GNT_VC1);

    assign idle = vc0_empty && vc1_empty && !d0_push && !d1_push;

    // Push stage and burst counter; reset drops any in-flight push immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            d0_push   <= 1'b0;
            d1_push   <= 1'b0;
            data_out  <= '0;
            burst_cnt <= '0;
        end else begin
            case (grant)
                GNT_VC0: begin
                    d0_push  <= !gnt_dest;
                    d1_push  <= gnt_dest;
                    data_out <= gnt_data;
                    if (burst_cnt != BURST_MAX) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                GNT_VC1: begin
                    d0_push   <= !gnt_dest;
                    d1_push   <= gnt_dest;
                    data_out  <= gnt_data;
                    burst_cnt <= '0;
                end
                default: begin
                    d0_push <= 1'b0;
                    d1_push <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed testbench for vc_arbiter. Inputs change on the falling edge.
// Combinational pops are checked 1 ns later, in the same cycle.
// Registered outputs are checked on the falling edge after the grant.

module tb_vc_arbiter;

    logic        clk;
    logic        reset;
    logic [11:0] vc0_data;
    logic        vc0_empty;
    logic        vc0_pop;
    logic [11:0] vc1_data;
    logic        vc1_empty;
    logic        vc1_pop;
    logic        d0_almost_full;
    logic        d1_almost_full;
    logic        d0_push;
    logic        d1_push;
    logic [11:0] data_out;
    logic        idle;

    int n_vec;
    int n_err;

    vc_arbiter #(
        .LINE_SIZE(12),
        .DEST_BIT (11),
        .BURST    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vc0_data      (vc0_data),
        .vc0_empty     (vc0_empty),
        .vc0_pop       (vc0_pop),
        .vc1_data      (vc1_data),
        .vc1_empty     (vc1_empty),
        .vc1_pop       (vc1_pop),
        .d0_almost_full(d0_almost_full),
        .d1_almost_full(d1_almost_full),
        .d0_push       (d0_push),
        .d1_push       (d1_push),
        .data_out      (data_out),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected grant pattern with both sources always full: bit i set means VC1.
    logic [7:0]  seq;
    logic [11:0] prev_word;
    logic        prev_vc1;

    initial begin
        n_vec = 0;
        n_err = 0;
        seq   = 8'b1000_1000;
        reset          = 1'b0;
        vc0_empty      = 1'b1;
        vc1_empty      = 1'b1;
        vc0_data       = '0;
        vc1_data       = '0;
        d0_almost_full = 1'b0;
        d1_almost_full = 1'b0;

        // ---- reset with both sources empty, then both non-empty
        repeat (2) @(negedge clk);
        #1;
        check("rst_idle_empty", idle, 1);
        vc0_empty = 1'b0; vc0_data = 12'h0A5;
        vc1_empty = 1'b0; vc1_data = 12'h8F0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_vc0_pop", vc0_pop, 0);
        check("rst_vc1_pop", vc1_pop, 0);
        check("rst_d0_push", d0_push, 0);
        check("rst_d1_push", d1_push, 0);
        check("rst_data_out", data_out, 12'h000);
        check("rst_idle_busy", idle, 0);

        // ---- release reset, single route VC0 -> D0
        @(negedge clk);
        vc1_empty = 1'b1;
        reset     = 1'b1;
        #1;
        check("rel_vc0_pop", vc0_pop, 1);
        check("rel_vc1_pop", vc1_pop, 0);
        @(negedge clk);
        vc0_empty = 1'b1;
        #1;
        check("r0_d0_push", d0_push, 1);
        check("r0_d1_push", d1_push, 0);
        check("r0_data", data_out, 12'h0A5);
        check("r0_idle_busy", idle, 0);
        @(negedge clk);
        #1;
        check("r0_idle_after", idle, 1);
        check("r0_d0_push_off", d0_push, 0);
        check("r0_data_hold", data_out, 12'h0A5);

        // ---- routing by header: VC1 word with bit 11 set -> D1
        vc1_empty = 1'b0; vc1_data = 12'h8F0;
        #1;
        check("r1_vc1_pop", vc1_pop, 1);
        check("r1_vc0_pop", vc0_pop, 0);
        @(negedge clk);
        vc1_empty = 1'b1;
        #1;
        check("r1_d1_push", d1_push, 1);
        check("r1_d0_push", d0_push, 0);
        check("r1_data", data_out, 12'h8F0);

        // ---- anti-starvation: both sources full, destinations free
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vc0_empty = 1'b0; vc0_data = 12'(12'h010 + i);
            vc1_empty = 1'b0; vc1_data = 12'(12'h820 + i);
            #1;
            if (i > 0) begin
                check("as_data", data_out, prev_word);
                check("as_d1_push", d1_push, prev_vc1);
                check("as_d0_push", d0_push, !prev_vc1);
            end
            check("as_vc1_pop", vc1_pop, seq[i]);
            check("as_vc0_pop", vc0_pop, !seq[i]);
            prev_vc1  = seq[i];
            prev_word = seq[i] ? 12'(12'h820 + i) : 12'(12'h010 + i);
        end
        @(negedge clk);
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;
        #1;
        check("as_last_data", data_out, prev_word);
        check("as_last_d1", d1_push, 1);

        // ---- backpressure: VC0 -> D0 blocked, VC1 -> D1 free
        @(negedge clk);
        d0_almost_full = 1'b1;
        vc0_empty = 1'b0; vc0_data = 12'h0C3;
        vc1_empty = 1'b0; vc1_data = 12'h8C4;
        #1;
        check("bp_vc0_blocked", vc0_pop, 0);
        check("bp_vc1_pop", vc1_pop, 1);
        @(negedge clk);
        vc1_data = 12'h8C5;
        d1_almost_full = 1'b1;
        #1;
        check("bp_d1_push", d1_push, 1);
        check("bp_data", data_out, 12'h8C4);
        check("bp_both_vc0", vc0_pop, 0);
        check("bp_both_vc1", vc1_pop, 0);
        @(negedge clk);
        #1;
        check("bp_no_d0", d0_push, 0);
        check("bp_no_d1", d1_push, 0);
        check("bp_data_hold", data_out, 12'h8C4);
        d0_almost_full = 1'b0;
        #1;
        check("bp_rel_vc0", vc0_pop, 1);
        check("bp_rel_vc1", vc1_pop, 0);
        @(negedge clk);
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;
        d1_almost_full = 1'b0;
        #1;
        check("bp_rel_push", d0_push, 1);
        check("bp_rel_data", data_out, 12'h0C3);

        // ---- reset mid-stream while d0_push is high
        @(negedge clk);
        vc0_empty = 1'b0; vc0_data = 12'h0D7;
        #1;
        check("mr_vc0_pop", vc0_pop, 1);
        @(negedge clk);
        vc0_empty = 1'b1;
        #1;
        check("mr_d0_push", d0_push, 1);
        check("mr_data", data_out, 12'h0D7);
        #2;
        reset = 1'b0;
        #1;
        check("mr_async_push", d0_push, 0);
        check("mr_async_data", data_out, 12'h000);
        check("mr_idle", idle, 1);
        vc0_empty = 1'b0; vc0_data = 12'h033;
        vc1_empty = 1'b0; vc1_data = 12'h844;
        #1;
        check("mr_pop_forced", vc0_pop, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("mr_seq_vc1", vc1_pop, seq[i]);
            check("mr_seq_vc0", vc0_pop, !seq[i]);
        end

        // ---- burst counter saturates while VC1 is absent, VC1 then wins at once
        @(negedge clk);
        vc1_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("sat_vc0_pop", vc0_pop, 1);
            @(negedge clk);
        end
        vc1_empty = 1'b0;
        #1;
        check("sat_vc1_first", vc1_pop, 1);
        check("sat_vc0_wait", vc0_pop, 0);
        @(negedge clk);
        #1;
        check("sat_vc0_back", vc0_pop, 1);
        check("sat_vc1_push", d1_push, 1);

        @(negedge clk);
        vc0_empty = 1'b1;
        vc1_empty = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("end_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
